// File: rtl/ysyx_041461_if_stage.sv
// ysyx_041461_if_stage: instruction fetch stage feeding the ID register.
// Purpose : keeps the fetch pc, runs the single-outstanding fetch handshake,
//           and presents one fetched instruction (or fetch trap) to decode.
// Build   : define YSYX_041461_IF_SKID_EN to allow a fetch ahead of a full
//           output slot, with a one-entry skid buffer behind the slot.
// Ports   :
//   clk, rst (async active-low)         clock and reset
//   IF_ready_in                         ID register accepts the slot this cycle
//   redirect_valid, redirect_pc         new fetch target from a later stage
//   inst_req_valid/ready, inst_req_addr fetch request handshake
//   inst_resp_valid/data/err            fetch response (always accepted)
//   IF_valid_out, IF_trap_out,
//   IF_inst_out, IF_pc_out              output slot towards ID
// Trap codes: 0 none, 1 instruction address misaligned, 2 instruction access fault.
module ysyx_041461_if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_ready_in,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_req_valid,
  input  logic        inst_req_ready,
  output logic [63:0] inst_req_addr,
  input  logic        inst_resp_valid,
  input  logic [31:0] inst_resp_data,
  input  logic        inst_resp_err,
  output logic        IF_valid_out,
  output logic [3:0]  IF_trap_out,
  output logic [31:0] IF_inst_out,
  output logic [63:0] IF_pc_out
);
  localparam logic [3:0] TRAP_NOP       = 4'd0;
  localparam logic [3:0] TRAP_IMISALIGN = 4'd1;
  localparam logic [3:0] TRAP_IACCESS   = 4'd2;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
  state_t      state, state_nx;
  logic [63:0] pc, pc_nx;
  logic        misaligned, consume, slot_free, can_issue, handshake, new_valid;
  logic [3:0]  new_trap;
  logic [31:0] new_inst;
`ifdef YSYX_041461_IF_SKID_EN
  logic        skid_valid;
  logic [3:0]  skid_trap;
  logic [31:0] skid_inst;
  logic [63:0] skid_pc;
  assign can_issue = ~skid_valid;
`else
  assign can_issue = slot_free;
`endif
  assign misaligned     = |pc[1:0];
  assign consume        = IF_valid_out & IF_ready_in;
  assign slot_free      = ~IF_valid_out | IF_ready_in;
  assign inst_req_valid = (state == REQ) & can_issue & ~misaligned;
  assign inst_req_addr  = pc;
  assign handshake      = inst_req_valid & inst_req_ready;
  // A new entry is either a misaligned-pc trap made locally in REQ or a
  // response in WAIT; a redirect in the same cycle kills it.
  assign new_valid = ~redirect_valid &
                     (((state == REQ) & can_issue & misaligned) | ((state == WAIT) & inst_resp_valid));
  assign new_trap  = (state == REQ) ? TRAP_IMISALIGN : inst_resp_err ? TRAP_IACCESS : TRAP_NOP;
  assign new_inst  = (state == REQ) ? 32'h0 : inst_resp_data;
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    if (redirect_valid) begin
      pc_nx    = redirect_pc;
      // A request already accepted by memory still owes one response, unless
      // that response is arriving right now.
      state_nx = (handshake || ((state == WAIT || state == DROP) && !inst_resp_valid)) ? DROP : REQ;
    end else begin
      pc_nx = new_valid ? pc + 64'd4 : pc;
      case (state)
        IDLE:    state_nx = REQ;
        REQ:     state_nx = handshake ? WAIT : (can_issue || consume) ? REQ : HOLD;
        WAIT:    state_nx = !inst_resp_valid ? WAIT : slot_free ? REQ : HOLD;
        HOLD:    state_nx = consume ? REQ : HOLD;
        DROP:    state_nx = inst_resp_valid ? REQ : DROP;
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IF_valid_out <= 1'b0;
      IF_trap_out  <= TRAP_NOP;
      IF_inst_out  <= 32'h0;
      IF_pc_out    <= RESET_PC;
    end else if (redirect_valid) begin
      IF_valid_out <= 1'b0;
`ifdef YSYX_041461_IF_SKID_EN
    end else if (skid_valid && consume) begin
      IF_trap_out <= skid_trap;
      IF_inst_out <= skid_inst;
      IF_pc_out   <= skid_pc;
`endif
    end else if (new_valid && slot_free) begin
      IF_valid_out <= 1'b1;
      IF_trap_out  <= new_trap;
      IF_inst_out  <= new_inst;
      IF_pc_out    <= pc;
    end else if (consume) begin
      IF_valid_out <= 1'b0;
    end
  end
`ifdef YSYX_041461_IF_SKID_EN
  // Requests stop while the skid is full, so a new entry never meets a full skid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_valid <= 1'b0;
      skid_trap  <= TRAP_NOP;
      skid_inst  <= 32'h0;
      skid_pc    <= RESET_PC;
    end else if (redirect_valid || (skid_valid && consume)) begin
      skid_valid <= 1'b0;
    end else if (new_valid && !slot_free) begin
      skid_valid <= 1'b1;
      skid_trap  <= new_trap;
      skid_inst  <= new_inst;
      skid_pc    <= pc;
    end
  end
`endif
endmodule

// File: doc/ysyx_041461_if_stage.md
YSYX_041461_IF_STAGE -- requirements
Module: ysyx_041461_IF_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port IF_ready_in, input, 1, downstream ID register enable; high means the output slot is accepted this cycle.
REQ-005 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 64): branch/jump/trap target from a later stage.
REQ-006 SHALL have ports inst_req_valid (output, 1), inst_req_ready (input, 1) and inst_req_addr (output, 64): fetch request handshake.
REQ-007 SHALL have ports inst_resp_valid (input, 1), inst_resp_data (input, 32) and inst_resp_err (input, 1): fetch response, always accepted.
REQ-008 SHALL have ports IF_valid_out (output, 1), IF_trap_out (output, 4), IF_inst_out (output, 32) and IF_pc_out (output, 64), feeding the ID register.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT, HOLD and DROP.
REQ-010 SHALL leave IDLE for REQ one cycle after reset deassertion, with pc = RESET_PC.
REQ-011 SHALL assert inst_req_valid with inst_req_addr = pc only in REQ, moving to WAIT on inst_req_valid && inst_req_ready.
REQ-012 SHALL, in WAIT on inst_resp_valid, load the output slot: valid 1; inst = inst_resp_data; pc = fetch pc; trap = TRAP_IACCESS if inst_resp_err, else TRAP_NOP.
REQ-013 SHALL, on the WAIT-to-load transition, advance pc by 4 with 64-bit wrap-around.
REQ-014 SHALL issue no memory request when pc[1:0] != 0; instead it loads the slot directly from REQ with trap TRAP_IMISALIGN and inst 0.
REQ-015 SHALL hold all output slot fields stable while IF_valid_out = 1 and IF_ready_in = 0 (state HOLD).
REQ-016 SHALL clear IF_valid_out on consumption (IF_valid_out && IF_ready_in) unless a new entry loads in the same cycle.
REQ-017 SHALL give redirect_valid priority over every other event: next cycle pc = redirect_pc, IF_valid_out = 0, any held or skid entry discarded.
REQ-018 SHALL, on redirect in REQ without a handshake, retract the request and re-enter REQ at the new pc (address change permitted).
REQ-019 SHALL, on redirect in WAIT, or in REQ with a handshake the same cycle, enter DROP; the next response is discarded, then the FSM enters REQ.
REQ-020 SHALL, on redirect in DROP coincident with the stale response, discard that response, update pc and enter REQ.
REQ-021 SHALL have a best-case throughput of one instruction per two cycles (REQ, then WAIT with a zero-latency response).

Reset
REQ-022 SHALL, while rst = 0, force: state IDLE; pc = RESET_PC; IF_valid_out 0; IF_trap_out TRAP_NOP; IF_inst_out 0; IF_pc_out RESET_PC; inst_req_valid 0; skid entry empty.
REQ-023 SHALL, on reset assertion mid-transaction, abandon the outstanding request; a response arriving after reset release while in IDLE is ignored.

Configuration
REQ-024 SHALL use macro YSYX_041461_IF_SKID_EN to select fetch-ahead buffering.
REQ-025 SHALL, when YSYX_041461_IF_SKID_EN is defined, allow a new request while the output slot is full; a response arriving with the slot full goes to a one-entry skid buffer, which moves to the slot on consumption; no new request is issued while the skid is full.
REQ-026 SHALL, when YSYX_041461_IF_SKID_EN is undefined, have no skid storage and enter REQ only once the output slot is empty or being consumed.

Verification
REQ-027 SHALL cover: reset release; memory ready=1, resp next cycle data 32'h0000_0013 -> slot pc 0x8000_0000, inst 0x13, trap NOP; next request addr 0x8000_0004.
REQ-028 SHALL cover: IF_ready_in=0 for 5 cycles with the slot full -> outputs constant; without SKID, inst_req_valid=0 throughout.
REQ-029 SHALL cover: redirect_valid with redirect_pc=0x8000_0100 during WAIT -> stale response dropped, IF_valid_out 0, next request addr 0x8000_0100.
REQ-030 SHALL cover: redirect_pc=0x8000_0102 -> no inst_req_valid; slot trap TRAP_IMISALIGN, pc 0x8000_0102, inst 0.
REQ-031 SHALL cover: inst_resp_err=1 -> slot trap TRAP_IACCESS; rst=0 asserted while in WAIT -> all outputs at reset values asynchronously.
REQ-032 SHALL cover, with SKID_EN: two responses with IF_ready_in=0 -> second held in skid; IF_ready_in=1 -> both delivered in order on consecutive cycles.
